lsu_align: RTL and testbench

- Load/store alignment unit between the CPU execute stage and the byte-banked data memory.
- The data memory handles only naturally aligned half-word and word accesses; it silently ignores the low address bits.
- Aligned requests pass straight through in the same cycle.
- Misaligned half/word requests are stalled and split into sequential byte accesses (sb / lbu). Load data is reassembled, sign- or zero-extended, and returned to the CPU.

---
 rtl/lsu_align.sv | 166 ++++++++++++++++
 tb/tb_lsu_align.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_align.sv
// Load/store alignment unit: aligned accesses pass through, misaligned
// half/word accesses are split into byte accesses and reassembled.
module lsu_align #(
    parameter bit SPLIT_MISALIGNED = 1'b1,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic                 req_read,
    input  logic                 req_write,
    input  logic [2:0]           req_size,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 busy,
    output logic                 resp_valid,
    output logic [31:0]          resp_rdata,
    output logic                 misalign_fault,
    output logic [CNT_WIDTH-1:0] split_count,
    output logic [31:0]          mem_access_addr,
    output logic [31:0]          mem_in,
    output logic                 mem_write_en,
    output logic                 mem_read_en,
    output logic [2:0]           mem_data_size,
    input  logic [31:0]          mem_out
);

    typedef enum logic [1:0] {IDLE, SPLIT, DONE} state_t;

    state_t               state;
    logic [1:0]           idx;
    logic [1:0]           last_idx;
    logic [31:0]          rbuf;
    logic [31:0]          base_addr;
    logic [31:0]          wdata_q;
    logic [2:0]           size_q;
    logic                 write_q;
    logic [CNT_WIDTH-1:0] cnt;

    logic op_wr;
    logic op_rd;
    logic is_byte;
    logic is_half;
    logic misaligned;
    logic start_split;

    always_comb begin
        op_wr       = req_write;
        op_rd       = req_read & ~req_write;
        is_byte     = (req_size == 3'b000) || (req_size == 3'b100);
        is_half     = (req_size == 3'b001) || (req_size == 3'b101);
        misaligned  = is_half ? req_addr[0]
                              : (!is_byte && (req_addr[1:0] != 2'b00));
        start_split = SPLIT_MISALIGNED && req_valid && (op_wr || op_rd)
                      && misaligned;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= 2'd0;
            last_idx  <= 2'd0;
            rbuf      <= 32'd0;
            base_addr <= 32'd0;
            wdata_q   <= 32'd0;
            size_q    <= 3'd0;
            write_q   <= 1'b0;
            cnt       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_split) begin
                        base_addr <= req_addr;
                        wdata_q   <= req_wdata;
                        size_q    <= req_size;
                        write_q   <= op_wr;
                        last_idx  <= is_half ? 2'd1 : 2'd3;
                        idx       <= 2'd0;
                        state     <= SPLIT;
                    end
                end
                SPLIT: begin
                    if (!write_q)
                        rbuf[{idx, 3'b000} +: 8] <= mem_out[7:0];
                    idx <= idx + 2'd1;
                    if (idx == last_idx)
                        state <= DONE;
                end
                DONE: begin
                    if (cnt != '1)
                        cnt <= cnt + CNT_WIDTH'(1);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign split_count = cnt;

    // Everything is forced low while reset is held, even the pass-through path.
    always_comb begin
        busy            = 1'b0;
        resp_valid      = 1'b0;
        resp_rdata      = 32'd0;
        misalign_fault  = 1'b0;
        mem_access_addr = 32'd0;
        mem_in          = 32'd0;
        mem_write_en    = 1'b0;
        mem_read_en     = 1'b0;
        mem_data_size   = 3'd0;
        if (!reset) begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (!(op_wr || op_rd)) begin
                            resp_valid = 1'b1;
                        end else if (misaligned) begin
                            if (SPLIT_MISALIGNED) begin
                                busy = 1'b1;
                            end else begin
                                misalign_fault = 1'b1;
                                resp_valid     = 1'b1;
                            end
                        end else begin
                            mem_access_addr = req_addr;
                            mem_in          = req_wdata;
                            mem_data_size   = req_size;
                            mem_write_en    = op_wr;
                            mem_read_en     = op_rd;
                            resp_valid      = 1'b1;
                            resp_rdata      = op_rd ? mem_out : 32'd0;
                        end
                    end
                end
                SPLIT: begin
                    busy            = 1'b1;
                    mem_access_addr = base_addr + 32'(idx);
                    if (write_q) begin
                        mem_data_size = 3'b000;
                        mem_in        = {24'd0, wdata_q[{idx, 3'b000} +: 8]};
                        mem_write_en  = 1'b1;
                    end else begin
                        mem_data_size = 3'b100;
                        mem_read_en   = 1'b1;
                    end
                end
                DONE: begin
                    resp_valid = 1'b1;
                    if (!write_q) begin
                        unique case (1'b1)
                            (size_q == 3'b001):
                                resp_rdata = {{16{rbuf[15]}}, rbuf[15:0]};
                            (size_q == 3'b101):
                                resp_rdata = {16'd0, rbuf[15:0]};
                            default:
                                resp_rdata = rbuf;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_align.sv
// Bench for lsu_align: directed vector table, reset/fault sequences and
// randomized requests against a byte-level memory reference model.
module tb_lsu_align;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_read, req_write;
    logic [2:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        busy, resp_valid, misalign_fault;
    logic [31:0] resp_rdata;
    logic [15:0] split_count;
    logic [31:0] mem_access_addr, mem_in, mem_out;
    logic        mem_write_en, mem_read_en;
    logic [2:0]  mem_data_size;

    logic        f_req_valid, f_req_read, f_req_write;
    logic [2:0]  f_req_size;
    logic [31:0] f_req_addr, f_req_wdata;
    logic        f_busy, f_resp_valid, f_misalign_fault;
    logic [31:0] f_resp_rdata;
    logic [15:0] f_split_count;
    logic [31:0] f_mem_access_addr, f_mem_in, f_mem_out;
    logic        f_mem_write_en, f_mem_read_en;
    logic [2:0]  f_mem_data_size;

    always #5 clk = ~clk;

    lsu_align u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_read(req_read), .req_write(req_write),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .misalign_fault(misalign_fault), .split_count(split_count),
        .mem_access_addr(mem_access_addr), .mem_in(mem_in),
        .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
        .mem_data_size(mem_data_size), .mem_out(mem_out)
    );

    lsu_align #(.SPLIT_MISALIGNED(1'b0)) u_fault (
        .clk(clk), .reset(reset),
        .req_valid(f_req_valid), .req_read(f_req_read),
        .req_write(f_req_write), .req_size(f_req_size),
        .req_addr(f_req_addr), .req_wdata(f_req_wdata),
        .busy(f_busy), .resp_valid(f_resp_valid),
        .resp_rdata(f_resp_rdata), .misalign_fault(f_misalign_fault),
        .split_count(f_split_count), .mem_access_addr(f_mem_access_addr),
        .mem_in(f_mem_in), .mem_write_en(f_mem_write_en),
        .mem_read_en(f_mem_read_en), .mem_data_size(f_mem_data_size),
        .mem_out(f_mem_out)
    );

    assign f_mem_out = f_mem_read_en ? 32'h1234_5678 : 32'd0;

    // 64-byte data memory, mirrored over the whole address space.
    logic [7:0] mem [64];
    logic [7:0] img [64];
    logic [7:0] ref_mem [64];
    logic       load_img;
    logic [5:0] ra;

    always @(posedge clk) begin
        if (load_img) begin
            for (int i = 0; i < 64; i++) mem[i] <= img[i];
        end else if (mem_write_en) begin
            case (mem_data_size[1:0])
                2'b00: mem[mem_access_addr[5:0]] <= mem_in[7:0];
                2'b01: begin
                    mem[{mem_access_addr[5:1], 1'b0}] <= mem_in[7:0];
                    mem[{mem_access_addr[5:1], 1'b1}] <= mem_in[15:8];
                end
                default: begin
                    mem[{mem_access_addr[5:2], 2'd0}] <= mem_in[7:0];
                    mem[{mem_access_addr[5:2], 2'd1}] <= mem_in[15:8];
                    mem[{mem_access_addr[5:2], 2'd2}] <= mem_in[23:16];
                    mem[{mem_access_addr[5:2], 2'd3}] <= mem_in[31:24];
                end
            endcase
        end
    end

    always_comb begin
        ra      = mem_access_addr[5:0];
        mem_out = 32'd0;
        if (mem_read_en) begin
            case (mem_data_size)
                3'b000: mem_out = {{24{mem[ra][7]}}, mem[ra]};
                3'b100: mem_out = {24'd0, mem[ra]};
                3'b001: mem_out = {{16{mem[{ra[5:1], 1'b1}][7]}},
                                   mem[{ra[5:1], 1'b1}], mem[{ra[5:1], 1'b0}]};
                3'b101: mem_out = {16'd0,
                                   mem[{ra[5:1], 1'b1}], mem[{ra[5:1], 1'b0}]};
                default: mem_out = {mem[{ra[5:2], 2'd3}], mem[{ra[5:2], 2'd2}],
                                    mem[{ra[5:2], 2'd1}], mem[{ra[5:2], 2'd0}]};
            endcase
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    logic [31:0] seen_addr[$];
    logic [2:0]  seen_size[$];

    // Called just after a rising edge; returns just after a rising edge.
    task automatic do_req(input logic rd, input logic wr, input logic [2:0] sz,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rdata, output int nbusy);
        bit timeout;
        req_valid = 1'b1; req_read = rd; req_write = wr;
        req_size = sz; req_addr = addr; req_wdata = wd;
        nbusy = 0; timeout = 1'b1; rdata = 32'hDEAD_BEEF;
        seen_addr.delete(); seen_size.delete();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (mem_read_en || mem_write_en) begin
                seen_addr.push_back(mem_access_addr);
                seen_size.push_back(mem_data_size);
            end
            if (resp_valid) begin
                rdata = resp_rdata;
                timeout = 1'b0;
            end else if (busy) begin
                nbusy++;
            end
            @(posedge clk); #1;
            if (!timeout) break;
        end
        req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
        if (timeout) begin
            checks++; errors++;
            $display("FAIL resp_timeout got none expected resp_valid");
        end
    endtask

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp;
        int          exp_busy;
    } vec_t;

    vec_t vt[7];

    logic [31:0] rdata, v, addr, wd;
    int          nb, exp_busy;
    logic [2:0]  sz;
    logic        rd, wr, is_rd, active, mis;
    logic [15:0] exp_cnt;
    logic [2:0]  szs [8];

    initial begin
        vt[0] = '{"lh7",   1, 0, 3'b001, 32'h7, 32'h0,          32'hFFFF8544, 3};
        vt[1] = '{"lhu7",  1, 0, 3'b101, 32'h7, 32'h0,          32'h00008544, 3};
        vt[2] = '{"lb8",   1, 0, 3'b000, 32'h8, 32'h0,          32'hFFFFFF85, 0};
        vt[3] = '{"noop",  0, 0, 3'b010, 32'h5, 32'h0,          32'h0,        0};
        vt[4] = '{"sw6",   0, 1, 3'b010, 32'h6, 32'hA1B2C3D4,   32'h0,        5};
        vt[5] = '{"lw4b",  1, 0, 3'b010, 32'h4, 32'h0,          32'hC3D42211, 0};
        vt[6] = '{"lw8",   1, 0, 3'b010, 32'h8, 32'h0,          32'h0000A1B2, 0};
        szs = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

        reset = 1'b1; load_img = 1'b0;
        req_valid = 0; req_read = 0; req_write = 0;
        req_size = 0; req_addr = 0; req_wdata = 0;
        f_req_valid = 0; f_req_read = 0; f_req_write = 0;
        f_req_size = 0; f_req_addr = 0; f_req_wdata = 0;
        for (int i = 0; i < 64; i++) img[i] = 8'h00;
        img[4] = 8'h11; img[5] = 8'h22; img[6] = 8'h33;
        img[7] = 8'h44; img[8] = 8'h85; img[9] = 8'h66;
        load_img = 1'b1;
        @(posedge clk); #1 load_img = 1'b0;

        // Outputs stay low under reset even with a live aligned request.
        req_valid = 1; req_read = 1; req_size = 3'b010; req_addr = 32'h4;
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_read_en", 32'(mem_read_en), 0);
        chk("rst_write_en", 32'(mem_write_en), 0);
        chk("rst_addr", mem_access_addr, 0);
        chk("rst_count", 32'(split_count), 0);
        req_valid = 0; req_read = 0;
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;

        do_req(1, 0, 3'b010, 32'h4, 0, rdata, nb);
        chk("lw4_rdata", rdata, 32'h44332211);
        chk("lw4_busy", 32'(nb), 0);
        chk("lw4_nacc", 32'(seen_size.size()), 1);
        if (seen_size.size() > 0) chk("lw4_size", 32'(seen_size[0]), 3'b010);

        do_req(1, 0, 3'b010, 32'h5, 0, rdata, nb);
        chk("lw5_rdata", rdata, 32'h85443322);
        chk("lw5_busy", 32'(nb), 5);
        chk("lw5_nacc", 32'(seen_addr.size()), 4);
        for (int i = 0; i < 4 && i < seen_addr.size(); i++) begin
            chk($sformatf("lw5_addr%0d", i), seen_addr[i], 32'(5 + i));
            chk($sformatf("lw5_size%0d", i), 32'(seen_size[i]), 3'b100);
        end
        chk("lw5_count", 32'(split_count), 1);

        for (int i = 0; i < 7; i++) begin
            do_req(vt[i].rd, vt[i].wr, vt[i].sz, vt[i].addr, vt[i].wd, rdata, nb);
            chk({vt[i].name, "_rdata"}, rdata, vt[i].exp);
            chk({vt[i].name, "_busy"}, 32'(nb), 32'(vt[i].exp_busy));
        end
        chk("sw6_bytes", {mem[9], mem[8], mem[7], mem[6]}, 32'hA1B2C3D4);
        chk("tbl_count", 32'(split_count), 4);

        // Reset after the second byte of a split store.
        req_valid = 1; req_write = 1; req_size = 3'b010;
        req_addr = 32'h6; req_wdata = 32'h5A6B7C8D;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("mid_busy", 32'(busy), 0);
        chk("mid_write_en", 32'(mem_write_en), 0);
        chk("mid_resp_valid", 32'(resp_valid), 0);
        chk("mid_count", 32'(split_count), 0);
        req_valid = 0; req_write = 0;
        @(posedge clk); #1;
        chk("mid_bytes", {mem[9], mem[8], mem[7], mem[6]}, 32'hA1B27C8D);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        do_req(1, 0, 3'b010, 32'h4, 0, rdata, nb);
        chk("post_rst_rdata", rdata, 32'h7C8D2211);
        chk("post_rst_busy", 32'(nb), 0);

        // Non-splitting variant rejects misaligned requests.
        f_req_valid = 1; f_req_read = 1; f_req_size = 3'b010; f_req_addr = 32'h5;
        #1;
        chk("f_lw5_fault", 32'(f_misalign_fault), 1);
        chk("f_lw5_resp", 32'(f_resp_valid), 1);
        chk("f_lw5_busy", 32'(f_busy), 0);
        chk("f_lw5_en", {30'd0, f_mem_read_en, f_mem_write_en}, 0);
        @(posedge clk); #1;
        f_req_read = 0; f_req_write = 1; f_req_size = 3'b001; f_req_addr = 32'h7;
        #1;
        chk("f_sh7_fault", 32'(f_misalign_fault), 1);
        chk("f_sh7_en", {30'd0, f_mem_read_en, f_mem_write_en}, 0);
        @(posedge clk); #1;
        f_req_write = 0; f_req_read = 1; f_req_size = 3'b010; f_req_addr = 32'h8;
        #1;
        chk("f_lw8_fault", 32'(f_misalign_fault), 0);
        chk("f_lw8_resp", 32'(f_resp_valid), 1);
        chk("f_lw8_rdata", f_resp_rdata, 32'h12345678);
        chk("f_count", 32'(f_split_count), 0);
        @(posedge clk); #1;
        f_req_valid = 0; f_req_read = 0;

        // Randomized requests against a byte-array reference.
        for (int i = 0; i < 64; i++) begin
            img[i] = 8'($urandom);
            ref_mem[i] = img[i];
        end
        load_img = 1'b1;
        @(posedge clk); #1 load_img = 1'b0;
        exp_cnt = split_count;
        for (int t = 0; t < 400; t++) begin
            int op;
            op = $urandom_range(0, 9);
            rd = (op >= 1 && op <= 4);
            wr = (op >= 5);
            if (wr && $urandom_range(0, 3) == 0) rd = 1'b1;
            sz = szs[$urandom_range(0, 7)];
            addr = $urandom;
            if ($urandom_range(0, 3) == 0)
                addr = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            wd = $urandom;
            nb = (sz == 3'd0 || sz == 3'd4) ? 1 :
                 (sz == 3'd1 || sz == 3'd5) ? 2 : 4;
            is_rd = rd && !wr;
            active = rd || wr;
            mis = (addr % 32'(nb)) != 0;
            exp_busy = (active && mis) ? nb + 1 : 0;
            v = 32'd0;
            if (is_rd) begin
                for (int k = 0; k < nb; k++)
                    v = v | (32'(ref_mem[6'(addr + 32'(k))]) << (8 * k));
                if (sz == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
                if (sz == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
            end
            if (wr) begin
                for (int k = 0; k < nb; k++)
                    ref_mem[6'(addr + 32'(k))] = 8'(wd >> (8 * k));
            end
            if (active && mis) exp_cnt = exp_cnt + 16'd1;
            do_req(rd, wr, sz, addr, wd, rdata, nb);
            chk($sformatf("rnd%0d_rdata", t), rdata, v);
            chk($sformatf("rnd%0d_busy", t), 32'(nb), 32'(exp_busy));
            chk($sformatf("rnd%0d_count", t), 32'(split_count), 32'(exp_cnt));
        end
        for (int i = 0; i < 64; i++)
            chk($sformatf("mem_byte%0d", i), 32'(mem[i]), 32'(ref_mem[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
